// File: rtl/high_level.sv
// Priority-queue demo core: LFSR fills a sorted 8-entry min-queue,
// then drains it in ascending order onto an RGB display.
module high_level (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       sigIDLE,
  output logic       sigSTART,
  output logic       sigADD,
  output logic       sigREMOVE,
  output logic       sigDISPLAY,
  output logic       sigFULL,
  output logic       sigEMPTY
);

  localparam int I_IDLE = 0;
  localparam int I_START = 1;
  localparam int I_ADD = 2;
  localparam int I_REM = 3;
  localparam int I_DISP = 4;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_ADD = 5'b00100;
  localparam logic [4:0] S_REM = 5'b01000;
  localparam logic [4:0] S_DISP = 5'b10000;

  logic [4:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [7:0]      data1_q, data1_d;
  logic [7:0]      data2_q, data2_d;
  logic [7:0][7:0] pq_q, pq_d;
  logic [7:0][7:0] ins;
  logic [7:0]      above;
  logic [7:0]      lfsr_nx;

  assign lfsr_nx = {lfsr_q[6:0],
                    lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Slots at/above the insertion point take their lower neighbour;
  // strict > keeps equal keys ahead of the new one.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      above[i] = (4'(i) >= cnt_q) || (pq_q[i] > lfsr_q);
    end
    ins[0] = above[0] ? lfsr_q : pq_q[0];
    for (int i = 1; i < 8; i++) begin
      if (!above[i]) ins[i] = pq_q[i];
      else if (above[i-1]) ins[i] = pq_q[i-1];
      else ins[i] = lfsr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    lfsr_d  = lfsr_q;
    data1_d = data1_q;
    data2_d = data2_q;
    pq_d    = pq_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (start) state_d = S_START;
      end
      state_q[I_START]: begin
        cnt_d   = '0;
        state_d = S_ADD;
      end
      state_q[I_ADD]: begin
        if (cnt_q != 4'd8) begin
          pq_d    = ins;
          cnt_d   = cnt_q + 4'd1;
          data1_d = lfsr_q;
          lfsr_d  = lfsr_nx;
        end
        if (cnt_q >= 4'd7) state_d = S_REM;
      end
      state_q[I_REM]: begin
        if (cnt_q != 4'd0) begin
          data2_d = pq_q[0];
          pq_d    = {8'h00, pq_q[7:1]};
          cnt_d   = cnt_q - 4'd1;
        end
        dcnt_d  = '0;
        state_d = S_DISP;
      end
      state_q[I_DISP]: begin
        dcnt_d = dcnt_q + 2'd1;
        if (dcnt_q == 2'd3) begin
          state_d = (cnt_q != 4'd0) ? S_REM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      lfsr_q  <= 8'hA5;
      data1_q <= '0;
      data2_q <= '0;
      pq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      lfsr_q  <= lfsr_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      pq_q    <= pq_d;
    end
  end

  assign data1      = data1_q;
  assign data2      = data2_q;
  assign sigIDLE    = state_q[I_IDLE];
  assign sigSTART   = state_q[I_START];
  assign sigADD     = state_q[I_ADD];
  assign sigREMOVE  = state_q[I_REM];
  assign sigDISPLAY = state_q[I_DISP];
  assign sigFULL    = (cnt_q == 4'd8);
  assign sigEMPTY   = (cnt_q == 4'd0);
  assign red        = sigDISPLAY ? data2_q[7:5] : 3'd0;
  assign green      = sigDISPLAY ? data2_q[4:2] : 3'd0;
  assign blue       = sigDISPLAY ? {data2_q[1:0], 1'b0} : 3'd0;

endmodule

// File: tb/tb_high_level.sv
// Self-checking bench for high_level against a queue/LFSR model.
module tb_high_level;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data1, data2;
  logic [2:0] red, green, blue;
  logic       sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY;
  logic       sigFULL, sigEMPTY;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] fill_log [8];
  logic [7:0] pop_log [8];
  logic [8:0] rgb_log [8];

  high_level dut (
    .clk(clk), .rst(rst), .start(start),
    .data1(data1), .data2(data2),
    .red(red), .green(green), .blue(blue),
    .sigIDLE(sigIDLE), .sigSTART(sigSTART), .sigADD(sigADD),
    .sigREMOVE(sigREMOVE), .sigDISPLAY(sigDISPLAY),
    .sigFULL(sigFULL), .sigEMPTY(sigEMPTY)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] flags();
    return {sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY};
  endfunction

  // Entered on the START cycle sample; leaves on the IDLE sample.
  task automatic run_check(input bit rand_start);
    int keys[$];
    logic [7:0] exp;
    logic [8:0] exp_rgb;
    checks++;
    if (flags() !== 5'b01000) begin
      errors++;
      $display("FAIL start_flag: got %b exp 01000", flags());
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rand_start) start = 1'($urandom);
      checks++;
      if (flags() !== 5'b00100) begin
        errors++;
        $display("FAIL add_flag[%0d]: got %b exp 00100", k, flags());
      end
      if (k > 0) begin
        checks++;
        if (data1 !== fill_log[k-1]) begin
          errors++;
          $display("FAIL data1[%0d]: got %h exp %h", k-1, data1,
                   fill_log[k-1]);
        end
      end
      fill_log[k] = m_lfsr;
      keys.push_back(int'(m_lfsr));
      m_lfsr = lfsr_next(m_lfsr);
    end
    tick();
    checks++;
    if (data1 !== fill_log[7]) begin
      errors++;
      $display("FAIL data1[7]: got %h exp %h", data1, fill_log[7]);
    end
    keys.sort();
    for (int j = 0; j < 8; j++) begin
      if (rand_start) start = 1'($urandom);
      checks++;
      if (flags() !== 5'b00010 || sigFULL !== (j == 0) ||
          sigEMPTY !== 1'b0 || {red, green, blue} !== 9'd0) begin
        errors++;
        $display("FAIL remove[%0d]: flags %b full %b empty %b rgb %h",
                 j, flags(), sigFULL, sigEMPTY, {red, green, blue});
      end
      tick();
      exp = 8'(keys.pop_front());
      exp_rgb = {exp[7:5], exp[4:2], exp[1:0], 1'b0};
      pop_log[j] = data2;
      rgb_log[j] = {red, green, blue};
      checks++;
      if (data2 !== exp || sigEMPTY !== (j == 7) || sigFULL !== 1'b0) begin
        errors++;
        $display("FAIL pop[%0d]: data2 %h exp %h empty %b full %b",
                 j, data2, exp, sigEMPTY, sigFULL);
      end
      for (int d = 0; d < 4; d++) begin
        if (d > 0) tick();
        checks++;
        if (flags() !== 5'b00001 || {red, green, blue} !== exp_rgb) begin
          errors++;
          $display("FAIL disp[%0d.%0d]: flags %b rgb %h exp %h",
                   j, d, flags(), {red, green, blue}, exp_rgb);
        end
      end
      tick();
    end
    checks++;
    if (flags() !== 5'b10000 || {red, green, blue} !== 9'd0 ||
        sigEMPTY !== 1'b1) begin
      errors++;
      $display("FAIL end_idle: flags %b rgb %h empty %b",
               flags(), {red, green, blue}, sigEMPTY);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (flags() !== 5'b10000 || sigEMPTY !== 1'b1 || sigFULL !== 1'b0 ||
        data1 !== 8'h00 || data2 !== 8'h00 ||
        {red, green, blue} !== 9'd0) begin
      errors++;
      $display("FAIL %s: flags %b e %b f %b d1 %h d2 %h rgb %h", tag,
               flags(), sigEMPTY, sigFULL, data1, data2,
               {red, green, blue});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
  endtask

  task automatic test_fill_drain();
    logic [7:0] fill_ref [8];
    logic [7:0] pop_ref [8];
    fill_ref = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54, 8'hA9, 8'h53, 8'hA7};
    pop_ref = '{8'h2A, 8'h4A, 8'h53, 8'h54, 8'h95, 8'hA5, 8'hA7, 8'hA9};
    m_lfsr = 8'hA5;
    rst = 1'b1;
    tick();
    run_check(1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (fill_log[i] !== fill_ref[i] || pop_log[i] !== pop_ref[i]) begin
        errors++;
        $display("FAIL known_seq[%0d]: push %h exp %h pop %h exp %h", i,
                 fill_log[i], fill_ref[i], pop_log[i], pop_ref[i]);
      end
    end
    checks++;
    if (rgb_log[0] !== {3'd1, 3'd2, 3'd4}) begin
      errors++;
      $display("FAIL rgb_2A: got %h exp %h", rgb_log[0],
               {3'd1, 3'd2, 3'd4});
    end
  endtask

  task automatic test_back_to_back();
    tick();
    run_check(1'b1);
    checks++;
    if (fill_log[0] !== 8'h4E) begin
      errors++;
      $display("FAIL second_run_key: got %h exp 4e", fill_log[0]);
    end
  endtask

  task automatic test_idle_hold();
    rst = 1'b0;
    start = 1'b0;
    tick();
    rst = 1'b1;
    m_lfsr = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_reset_vals("idle_hold");
    end
  endtask

  task automatic test_mid_reset();
    int n;
    start = 1'b1;
    tick();
    n = 20 + int'($urandom_range(0, 3));
    for (int i = 0; i < n; i++) tick();
    checks++;
    if (sigDISPLAY !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_disp: got %b exp 1", sigDISPLAY);
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    #2;
    rst = 1'b1;
    m_lfsr = 8'hA5;
    tick();
    run_check(1'b0);
    checks++;
    if (fill_log[0] !== 8'hA5) begin
      errors++;
      $display("FAIL restart_key: got %h exp a5", fill_log[0]);
    end
  endtask

  task automatic test_random_gaps();
    int gap;
    for (int r = 0; r < 3; r++) begin
      start = 1'b0;
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++;
        if (flags() !== 5'b10000) begin
          errors++;
          $display("FAIL gap_idle[%0d]: got %b exp 10000", r, flags());
        end
      end
      start = 1'b1;
      tick();
      run_check(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_idle_hold();
    test_mid_reset();
    test_random_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
